// File: rtl/reg_write_arbiter_pkg.sv
// Shared register-file write-port constants, state encoding and payload type.
package reg_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  // One register-file write: destination and data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage : reg_write_arbiter_pkg

// File: rtl/reg_write_arbiter_starve_counter.sv
// Saturating count of consecutive cycles B has waited; flags the last wait before a forced grant.
module reg_write_arbiter_starve_counter #(
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_c = (cnt_q == HIT_VAL);

endmodule : reg_write_arbiter_starve_counter

// File: rtl/reg_write_arbiter.sv
// Arbitrates the register-file write port between writeback (A, priority) and mul/div (B),
// with a starvation guard that forces one B grant.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  input  logic [REG_ADDR_W-1:0] a_addr_i,
  input  logic [REG_DATA_W-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [REG_ADDR_W-1:0] b_addr_i,
  input  logic [REG_DATA_W-1:0] b_data_i,
  output logic                  b_ready_o,
  output logic                  reg_write_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_DATA_W-1:0] rd_data_o,
  output logic                  force_b_o
);

  arb_state_e state_q, state_d;
  wr_req_t    wr_q, wr_d;
  logic       reg_write_q, reg_write_d;
  logic       force_b_q, force_b_d;

  logic a_fire, b_fire, a_wr, b_wr, b_wait, cnt_hit;

  reg_write_arbiter_starve_counter #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (b_wait),
    .clr_i (!b_wait),
    .hit_c (cnt_hit)
  );

  // Readies, grant selection, next state and next write-port contents.
  always_comb begin
    a_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    state_d     = state_q;
    wr_d        = wr_q;
    reg_write_d = 1'b0;

    if (state_q == PRIO_A) begin
      a_ready_o = 1'b1;
      // B may share the cycle whenever A does not consume the port.
      b_ready_o = !a_valid_i || (a_addr_i == ZERO_REG) || (b_addr_i == ZERO_REG);
    end else begin
      b_ready_o = 1'b1;
    end

    a_fire = a_valid_i && a_ready_o;
    b_fire = b_valid_i && b_ready_o;
    b_wait = b_valid_i && !b_ready_o;

    // Register-0 writes are accepted but never reach the port.
    a_wr = a_fire && (a_addr_i != ZERO_REG);
    b_wr = b_fire && (b_addr_i != ZERO_REG) && !a_wr;

    if (a_wr) begin
      reg_write_d = 1'b1;
      wr_d        = '{addr: a_addr_i, data: a_data_i};
    end else if (b_wr) begin
      reg_write_d = 1'b1;
      wr_d        = '{addr: b_addr_i, data: b_data_i};
    end

    unique case (state_q)
      PRIO_A:  if (b_wait && cnt_hit) state_d = FORCE_B;
      FORCE_B: if (b_fire)            state_d = PRIO_A;
      default:                        state_d = PRIO_A;
    endcase

    force_b_d = (state_d == FORCE_B);
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= PRIO_A;
      wr_q        <= '0;
      reg_write_q <= 1'b0;
      force_b_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      reg_write_q <= reg_write_d;
      force_b_q   <= force_b_d;
    end
  end

  assign reg_write_o = reg_write_q;
  assign rd_addr_o   = wr_q.addr;
  assign rd_data_o   = wr_q.data;
  assign force_b_o   = force_b_q;

endmodule : reg_write_arbiter

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a randomized run
// against a requester-level model of the arbitration rules.
module tb_reg_write_arbiter;

  localparam int unsigned SL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_valid_i, b_valid_i;
  logic [4:0]  a_addr_i, b_addr_i;
  logic [31:0] a_data_i, b_data_i;
  logic        a_ready_o, b_ready_o, reg_write_o, force_b_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32];

  reg_write_arbiter #(.STARVE_LIMIT(SL), .CNT_W(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_addr_i    (a_addr_i),
    .a_data_i    (a_data_i),
    .a_ready_o   (a_ready_o),
    .b_valid_i   (b_valid_i),
    .b_addr_i    (b_addr_i),
    .b_data_i    (b_data_i),
    .b_ready_o   (b_ready_o),
    .reg_write_o (reg_write_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .force_b_o   (force_b_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file fed by the DUT write port.
  always @(posedge clk_i) begin
    if (reg_write_o) rf[rd_addr_o] <= rd_data_o;
  end

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    @(negedge clk_i);
    a_valid_i = av; a_addr_i = aa; a_data_i = ad;
    b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    a_valid_i = 0; a_addr_i = 0; a_data_i = 0;
    b_valid_i = 0; b_addr_i = 0; b_data_i = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 5'd7, 32'h77, 1, 5'd2, 32'h22);
    @(posedge clk_i); #1;
    checks++; if (reg_write_o !== 1'b1) begin failures++; $display("FAIL reset_pre_we got=%b exp=1", reg_write_o); end
    #2 rst_i = 1'b0; #1;
    checks++; if (reg_write_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", reg_write_o); end
    checks++; if (rd_addr_o !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rd_addr_o); end
    checks++; if (rd_data_o !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rd_data_o); end
    checks++; if (force_b_o !== 1'b0) begin failures++; $display("FAIL reset_force got=%b exp=0", force_b_o); end
    @(negedge clk_i);
    a_valid_i = 0; b_valid_i = 0;
    rst_i = 1'b1; #1;
    checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b exp=1", a_ready_o); end
    checks++; if (force_b_o !== 1'b0) begin failures++; $display("FAIL reset_force_rel got=%b exp=0", force_b_o); end
  endtask

  task automatic test_a_only;
    drive(1, 5'd8, 32'hAA, 0, 5'd0, 32'd0); #1;
    checks++; if (a_ready_o !== 1'b1) begin failures++; $display("FAIL aonly_ready got=%b exp=1", a_ready_o); end
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd8, 32'hAA}) begin
      failures++; $display("FAIL aonly_write got=%b/%0d/%0h exp=1/8/aa", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b0, 5'd8, 32'hAA}) begin
      failures++; $display("FAIL aonly_idle got=%b/%0d/%0h exp=0/8/aa", reg_write_o, rd_addr_o, rd_data_o);
    end
  endtask

  task automatic test_contention;
    drive(1, 5'd9, 32'h11, 1, 5'd10, 32'h22); #1;
    checks++; if ({a_ready_o, b_ready_o} !== 2'b10) begin failures++; $display("FAIL cont_ready1 got=%b%b exp=10", a_ready_o, b_ready_o); end
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd9, 32'h11}) begin
      failures++; $display("FAIL cont_first got=%b/%0d/%0h exp=1/9/11", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(0, 5'd0, 32'd0, 1, 5'd10, 32'h22); #1;
    checks++; if (b_ready_o !== 1'b1) begin failures++; $display("FAIL cont_ready2 got=%b exp=1", b_ready_o); end
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd10, 32'h22}) begin
      failures++; $display("FAIL cont_second got=%b/%0d/%0h exp=1/10/22", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk_i);
  endtask

  task automatic test_starvation;
    int k = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      logic ef;
      ef = (cyc == SL + 1);
      drive(1, 5'(8 + k), 32'(k), (cyc <= SL + 1), 5'd3, 32'h5A5A5A5A); #1;
      checks++; if ({a_ready_o, b_ready_o, force_b_o} !== {!ef, ef, ef}) begin
        failures++; $display("FAIL starve_ctl cyc=%0d got=%b%b%b exp=%b%b%b", cyc, a_ready_o, b_ready_o, force_b_o, !ef, ef, ef);
      end
      @(posedge clk_i); #1;
      if (ef) begin
        checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd3, 32'h5A5A5A5A}) begin
          failures++; $display("FAIL starve_b cyc=%0d got=%b/%0d/%0h exp=1/3/5a5a5a5a", cyc, reg_write_o, rd_addr_o, rd_data_o);
        end
      end else begin
        checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'(8 + k), 32'(k)}) begin
          failures++; $display("FAIL starve_a cyc=%0d got=%b/%0d/%0h exp=1/%0d/%0h", cyc, reg_write_o, rd_addr_o, rd_data_o, 8 + k, k);
        end
        k++;
      end
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0); #1;
    checks++; if (force_b_o !== 1'b0) begin failures++; $display("FAIL starve_end got=%b exp=0", force_b_o); end
    @(posedge clk_i);
  endtask

  task automatic test_zero_reg;
    drive(1, 5'd0, 32'hDEAD, 1, 5'd4, 32'h7); #1;
    checks++; if ({a_ready_o, b_ready_o} !== 2'b11) begin failures++; $display("FAIL zero_ready got=%b%b exp=11", a_ready_o, b_ready_o); end
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd4, 32'h7}) begin
      failures++; $display("FAIL zero_write got=%b/%0d/%0h exp=1/4/7", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(1, 5'd0, 32'hBEEF, 0, 5'd0, 32'd0);
    @(posedge clk_i); #1;
    checks++; if (reg_write_o !== 1'b0) begin failures++; $display("FAIL zero_a_only got=%b exp=0", reg_write_o); end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk_i);
  endtask

  task automatic test_same_addr;
    drive(1, 5'd5, 32'h1, 1, 5'd5, 32'h2);
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'h1}) begin
      failures++; $display("FAIL same_first got=%b/%0d/%0h exp=1/5/1", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(0, 5'd0, 32'd0, 1, 5'd5, 32'h2);
    @(posedge clk_i); #1;
    checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'h2}) begin
      failures++; $display("FAIL same_second got=%b/%0d/%0h exp=1/5/2", reg_write_o, rd_addr_o, rd_data_o);
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk_i); #1;
    checks++; if (rf[5] !== 32'h2) begin failures++; $display("FAIL same_rf got=%0h exp=2", rf[5]); end
  endtask

  // Random requesters obeying the hold rule; model tracks how long B has been kept waiting.
  task automatic test_random;
    logic        a_pend = 0, b_pend = 0;
    logic [4:0]  a_a = 0, b_a = 0, e_addr = 0;
    logic [31:0] a_d = 0, b_d = 0, e_data = 0;
    int          b_waited = 0;
    @(negedge clk_i);
    a_valid_i = 0; b_valid_i = 0;
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic forced, a_rdy, b_rdy, a_acc, b_acc, e_we;
      if (!a_pend && ($urandom_range(0, 3) != 0)) begin
        a_pend = 1; a_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); a_d = $urandom;
      end
      if (!b_pend && ($urandom_range(0, 2) == 0)) begin
        b_pend = 1; b_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)); b_d = $urandom;
      end
      forced = (b_waited >= SL);
      a_rdy  = !forced;
      b_rdy  = forced || !a_pend || (a_a == 5'd0) || (b_a == 5'd0);
      a_acc  = a_pend && a_rdy;
      b_acc  = b_pend && b_rdy;
      e_we   = 1'b0;
      if (a_acc && a_a != 5'd0) begin
        e_we = 1'b1; e_addr = a_a; e_data = a_d;
      end else if (b_acc && b_a != 5'd0) begin
        e_we = 1'b1; e_addr = b_a; e_data = b_d;
      end
      drive(a_pend, a_a, a_d, b_pend, b_a, b_d); #1;
      checks++; if ({a_ready_o, b_ready_o, force_b_o} !== {a_rdy, b_rdy, forced}) begin
        failures++; $display("FAIL rand_ctl n=%0d got=%b%b%b exp=%b%b%b", n, a_ready_o, b_ready_o, force_b_o, a_rdy, b_rdy, forced);
      end
      @(posedge clk_i); #1;
      checks++; if ({reg_write_o, rd_addr_o, rd_data_o} !== {e_we, e_addr, e_data}) begin
        failures++; $display("FAIL rand_port n=%0d got=%b/%0d/%0h exp=%b/%0d/%0h", n, reg_write_o, rd_addr_o, rd_data_o, e_we, e_addr, e_data);
      end
      b_waited = (b_pend && !b_rdy) ? b_waited + 1 : 0;
      if (a_acc) a_pend = 0;
      if (b_acc) b_pend = 0;
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(posedge clk_i);
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_starvation();
    test_zero_reg();
    test_same_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_write_arbiter

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters:
  - A: the pipeline writeback stage.
  - B: the multi-cycle mul/div unit.
- Sits directly in front of the register file and drives its write address, write data and write-enable inputs.
- A has fixed priority. A starvation counter forces a B grant and stalls A when B has waited too long.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles B may wait before a forced grant. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 3: width of the wait counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- a_valid_i  in  1  requester A has a write pending.
- a_addr_i  in  5  requester A destination register.
- a_data_i  in  32  requester A write data.
- a_ready_o  out  1  A's write is accepted this cycle.
- b_valid_i  in  1  requester B has a write pending.
- b_addr_i  in  5  requester B destination register.
- b_data_i  in  32  requester B write data.
- b_ready_o  out  1  B's write is accepted this cycle.
- reg_write_o  out  1  write enable to the register file.
- rd_addr_o  out  5  write address to the register file.
- rd_data_o  out  32  write data to the register file.
- force_b_o  out  1  high while in FORCE_B (A is stalled).

Behaviour:
- Reset: asynchronous, active-low. Takes effect immediately on rst_i low.
  - state=PRIO_A, wait_cnt=0.
  - reg_write_o=0, rd_addr_o=0, rd_data_o=0, force_b_o=0.
  - Handshakes in flight are discarded. Requesters re-present after reset.
- Handshake: a transfer occurs when valid && ready on a rising edge.
  - A requester holds valid, addr and data stable until ready.
  - Valid must not drop before acceptance.
- Readies are combinational from state and the inputs.
- State PRIO_A:
  - a_ready_o=1.
  - b_ready_o = !a_valid_i || (a_addr_i==0) || (b_addr_i==0).
- State FORCE_B:
  - a_ready_o=0.
  - b_ready_o=1.
- Writes to register 0:
  - Are accepted but dropped; the port is not consumed.
  - An A write to address 0 therefore leaves the port free for B in the same cycle.
  - A B write to address 0 is always accepted immediately in PRIO_A.
- Port use: at most one nonzero-address write is granted per cycle.
- Write port outputs are registered, with 1-cycle latency.
  - On a granted nonzero-address write, at the next edge: reg_write_o=1 and rd_addr_o/rd_data_o take the granted write.
  - Otherwise reg_write_o=0 at the next edge, and addr/data hold their previous values.
  - The register file commits on the following edge, so total handshake-to-commit is 2 edges.
- wait_cnt, saturating:
  - Increments each cycle that b_valid_i=1 and b_ready_o=0.
  - Clears when B transfers or when b_valid_i=0.
- Transition PRIO_A to FORCE_B: when b_valid_i && !b_ready_o && wait_cnt==STARVE_LIMIT-1.
  - The forced grant therefore lands in the (STARVE_LIMIT+1)th cycle of waiting.
- Transition FORCE_B to PRIO_A: after exactly one B transfer.
  - wait_cnt clears.
  - FORCE_B lasts 1 cycle when B is valid, which is guaranteed by the hold rule.
- force_b_o is the registered state decode.
- Ordering:
  - Writes commit in grant order.
  - When A and B target the same register in the same cycle, A commits first and B overwrites it later.
- No read-side forwarding is performed. The hazard unit accounts for the 2-edge commit.

Decomposition:
- Shared cpu package, constants only:
  - REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=0.
  - State encoding PRIO_A=1'b0, FORCE_B=1'b1.
- One sub-module is natural: starve_counter. It holds the saturating CNT_W counter with inc/clr inputs and a hit output at STARVE_LIMIT-1.
- The grant logic and output register remain in reg_write_arbiter.

Test Plan:
- Reset: hold rst_i=0 mid-stream with A and B valid -> all outputs 0 immediately. After release: state PRIO_A, a_ready_o=1.
- A only: A writes r8=0x0000_00AA -> a_ready_o=1. Next edge: reg_write_o=1, rd_addr_o=8, rd_data_o=0xAA. Following cycle with no request: reg_write_o=0.
- Contention: A (r9=0x11) and B (r10=0x22) both valid for one cycle, then A drops -> A granted first, B one cycle later. Write port shows r9 then r10 on consecutive cycles.
- Starvation, STARVE_LIMIT=4: A valid with nonzero address every cycle, B (r3=0x5A5A5A5A) valid -> B waits 4 cycles, then FORCE_B. a_ready_o=0 for exactly 1 cycle, B written, force_b_o pulses for 1 cycle, A resumes.
- Zero register: A writes r0 while B (r4=0x7) is valid -> both accepted in the same cycle. Only r4 appears on the port; no write to r0 is issued.
- Same-address race: A r5=0x1 and B r5=0x2 simultaneous -> commit order r5=0x1 then r5=0x2. A register file read afterwards returns 0x2.
